// File: rtl/fpu_seq_pkg.sv
// fpu_seq_pkg: shared types and constants for the FPU multicycle sequencer.
//   state_t    - sequencer FSM states (IDLE, EXEC, WB)
//   FP_*       - FPUControl op codes
//   lat_lookup - maps an op code to its EXEC cycle count
package fpu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [1:0] FP_ADD = 2'b00;
  localparam logic [1:0] FP_SUB = 2'b01;
  localparam logic [1:0] FP_MUL = 2'b10;
  localparam logic [1:0] FP_DIV = 2'b11;

  localparam int CNT_W = 4;

  // The latencies are module parameters, so they are passed in rather
  // than read from package scope.
  function automatic logic [CNT_W-1:0] lat_lookup(
    input logic [1:0] op,
    input int         lat_add,
    input int         lat_sub,
    input int         lat_mul,
    input int         lat_div
  );
    logic [CNT_W-1:0] lat;
    case (op)
      FP_ADD:  lat = CNT_W'(lat_add);
      FP_SUB:  lat = CNT_W'(lat_sub);
      FP_MUL:  lat = CNT_W'(lat_mul);
      default: lat = CNT_W'(lat_div);
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/fpu_seq_if.sv
// fpu_seq_if: bundle of the sequencer's core-side and FPU-side signals.
//   master - the surrounding core/FPU: drives the instruction, abort and
//            FPU result; observes held operands, stall and writeback.
//   slave  - the sequencer itself.
interface fpu_seq_if;
  // instruction issue
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  rd;
  logic        setflags;
  logic        abort;
  // combinational FPU
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_result;
  logic [3:0]  fpu_flags;
  // core control and writeback
  logic        stall;
  logic        busy;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flags_we;
  logic [3:0]  flags;

  modport master (
    output start, op, a, b, rd, setflags, abort, fpu_result, fpu_flags,
    input  fpu_a, fpu_b, fpu_op, stall, busy, wb_en, wb_addr, wb_data,
           flags_we, flags
  );

  modport slave (
    input  start, op, a, b, rd, setflags, abort, fpu_result, fpu_flags,
    output fpu_a, fpu_b, fpu_op, stall, busy, wb_en, wb_addr, wb_data,
           flags_we, flags
  );
endinterface

// File: rtl/fpu_seq_lat_counter.sv
// lat_counter: loadable down-counter timing the FPU multicycle path.
//   clk, reset - rising-edge clock, asynchronous active-low reset
//   load       - load load_val (takes priority over en)
//   load_val   - value to load
//   en         - decrement by one; holds at zero, never wraps
//   zero       - counter value is zero
module lat_counter
  import fpu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fpu_seq.sv
// fpu_seq: multicycle-path sequencer for the combinational FPU.
// Latches an FP instruction, holds its operands on the FPU for a per-op
// number of cycles while stalling the PC, captures result and flags, then
// issues a single-cycle register-file / flag writeback.
//   clk, reset - rising-edge clock, asynchronous active-low reset
//   bus        - fpu_seq_if.slave: issue (start/op/a/b/rd/setflags/abort),
//                FPU side (fpu_a/fpu_b/fpu_op in, fpu_result/fpu_flags back),
//                core side (stall, busy, wb_en/wb_addr/wb_data,
//                flags_we/flags)
//   LAT_*      - EXEC cycles per op, 1..15
module fpu_seq
  import fpu_seq_pkg::*;
#(
  parameter int LAT_ADD = 2,
  parameter int LAT_SUB = 2,
  parameter int LAT_MUL = 3,
  parameter int LAT_DIV = 6
) (
  input  logic     clk,
  input  logic     reset,
  fpu_seq_if.slave bus
);

  state_t      state_q;
  state_t      state_d;

  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  op_q;
  logic [3:0]  rd_q;
  logic        sf_q;
  logic [31:0] wb_data_q;
  logic [3:0]  flags_q;

  logic             accept;
  logic             cnt_zero;
  logic             capture;
  logic             hold;
  logic [CNT_W-1:0] load_val;

  // abort beats start, so an aborted issue latches nothing
  assign accept  = (state_q == IDLE) && bus.start && !bus.abort;
  assign capture = (state_q == EXEC) && cnt_zero && !bus.abort;
  // the counter is loaded with LAT-1 so that it reads zero in the last
  // EXEC cycle, giving exactly LAT cycles of EXEC
  assign load_val = lat_lookup(bus.op, LAT_ADD, LAT_SUB, LAT_MUL, LAT_DIV)
                    - CNT_W'(1);

  lat_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (load_val),
    .en       (state_q == EXEC),
    .zero     (cnt_zero)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.start) state_d = EXEC;
        EXEC:    if (cnt_zero)  state_d = WB;
        WB:      state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // output decode
  always_comb begin
    bus.stall    = 1'b0;
    bus.busy     = 1'b0;
    bus.wb_en    = 1'b0;
    bus.flags_we = 1'b0;
    hold         = 1'b0;
    case (state_q)
      IDLE: begin
        bus.stall = accept;
      end
      EXEC: begin
        bus.stall = 1'b1;
        bus.busy  = 1'b1;
        hold      = 1'b1;
      end
      WB: begin
        bus.busy     = 1'b1;
        bus.wb_en    = !bus.abort;
        bus.flags_we = sf_q && !bus.abort;
        hold         = 1'b1;
      end
      default: ;
    endcase
  end

  // operand latches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      rd_q <= '0;
      sf_q <= 1'b0;
    end else if (accept) begin
      a_q  <= bus.a;
      b_q  <= bus.b;
      op_q <= bus.op;
      rd_q <= bus.rd;
      sf_q <= bus.setflags;
    end
  end

  // result capture at the end of the last EXEC cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_data_q <= '0;
      flags_q   <= '0;
    end else if (capture) begin
      wb_data_q <= bus.fpu_result;
      flags_q   <= bus.fpu_flags;
    end
  end

  // FPU inputs are gated to zero in IDLE so the FPU does not toggle
  assign bus.fpu_a   = hold ? a_q  : '0;
  assign bus.fpu_b   = hold ? b_q  : '0;
  assign bus.fpu_op  = hold ? op_q : '0;

  assign bus.wb_addr = rd_q;
  assign bus.wb_data = wb_data_q;
  assign bus.flags   = flags_q;

endmodule

// File: tb/tb_fpu_seq.sv
module tb_fpu_seq;
  import fpu_seq_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fpu_seq_if bus ();

  fpu_seq u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // FPU stand-in: any deterministic function of its inputs, so that a
  // result depends on the operands actually held on the FPU.
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_res = '0;
  logic [3:0]  ovr_flags = '0;

  function automatic logic [35:0] fpu_fn(input logic [31:0] fa,
                                         input logic [31:0] fb,
                                         input logic [1:0]  fo);
    logic [31:0] r;
    r = (fa * 32'h9E3779B1) ^ {fb[15:0], fb[31:16]} ^ {30'd0, fo};
    return {r[31:28] ^ r[3:0], r};
  endfunction

  function automatic logic [35:0] fpu_ref(input logic [31:0] fa,
                                          input logic [31:0] fb,
                                          input logic [1:0]  fo);
    if (ovr_en) return {ovr_flags, ovr_res};
    return fpu_fn(fa, fb, fo);
  endfunction

  always_comb begin
    {bus.fpu_flags, bus.fpu_result} = fpu_ref(bus.fpu_a, bus.fpu_b, bus.fpu_op);
  end

  function automatic int lat_of(input logic [1:0] o);
    case (o)
      2'b00:   return 2;
      2'b01:   return 2;
      2'b10:   return 3;
      default: return 6;
    endcase
  endfunction

  // Reference model: one instruction in flight, described by its issue
  // cycle. EXEC is issue+1..issue+L, WB is issue+L+1.
  bit          m_busy = 0;
  int          m_iss = 0;
  int          m_lat = 0;
  logic [31:0] m_a, m_b;
  logic [1:0]  m_op;
  logic [3:0]  m_rd;
  logic        m_sf;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic st, input logic [1:0] o,
                      input logic [31:0] av, input logic [31:0] bv,
                      input logic [3:0] r, input logic sf, input logic ab,
                      output logic o_stall, output logic o_wb);
    int ph;
    logic ex, wbp;
    logic [35:0] res;
    @(negedge clk);
    bus.start = st; bus.op = o; bus.a = av; bus.b = bv;
    bus.rd = r; bus.setflags = sf; bus.abort = ab;
    #1;
    ex = 1'b0; wbp = 1'b0;
    if (m_busy) begin
      ph  = cyc - m_iss;
      ex  = (ph >= 1) && (ph <= m_lat);
      wbp = (ph == m_lat + 1);
    end
    check_eq("stall", bus.stall, ex | (!m_busy & st & !ab));
    check_eq("busy", bus.busy, m_busy);
    check_eq("wb_en", bus.wb_en, wbp & !ab);
    check_eq("flags_we", bus.flags_we, wbp & m_sf & !ab);
    if (!m_busy) begin
      check_eq("fpu_a_idle", bus.fpu_a, 0);
      check_eq("fpu_b_idle", bus.fpu_b, 0);
      check_eq("fpu_op_idle", bus.fpu_op, 0);
    end else if (ex) begin
      check_eq("fpu_a", bus.fpu_a, m_a);
      check_eq("fpu_b", bus.fpu_b, m_b);
      check_eq("fpu_op", bus.fpu_op, m_op);
    end
    if (wbp) begin
      res = fpu_ref(m_a, m_b, m_op);
      check_eq("wb_addr", bus.wb_addr, m_rd);
      check_eq("wb_data", bus.wb_data, res[31:0]);
      check_eq("flags", bus.flags, res[35:32]);
    end
    o_stall = bus.stall;
    o_wb    = bus.wb_en;
    @(posedge clk);
    if (ab || wbp) begin
      m_busy = 0;
    end else if (!m_busy && st) begin
      m_busy = 1; m_iss = cyc; m_lat = lat_of(o);
      m_a = av; m_b = bv; m_op = o; m_rd = r; m_sf = sf;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    logic s, w;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, s, w);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_stall"}, bus.stall, 0);
    check_eq({tag, "_busy"}, bus.busy, 0);
    check_eq({tag, "_wb_en"}, bus.wb_en, 0);
    check_eq({tag, "_flags_we"}, bus.flags_we, 0);
    check_eq({tag, "_wb_addr"}, bus.wb_addr, 0);
    check_eq({tag, "_wb_data"}, bus.wb_data, 0);
    check_eq({tag, "_flags"}, bus.flags, 0);
    check_eq({tag, "_fpu_a"}, bus.fpu_a, 0);
    check_eq({tag, "_fpu_b"}, bus.fpu_b, 0);
    check_eq({tag, "_fpu_op"}, bus.fpu_op, 0);
  endtask

  initial begin
    logic s, w;
    int wb_cnt;
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    bus.rd = 0; bus.setflags = 0; bus.abort = 0;

    // reset held low, then released
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("rst");
    @(negedge clk);
    reset = 1'b1;
    #1 check_zero_outputs("post_rst");
    idle(2);

    // FP_MUL 2.0 * 3.0 = 6.0, setflags=1; WB in cycle 4
    ovr_en = 1'b1; ovr_res = 32'h40C0_0000; ovr_flags = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      if (k == 0) step(1, FP_MUL, 32'h4000_0000, 32'h4040_0000, 4'd5, 1, 0, s, w);
      else        step(0, FP_MUL, 32'h1234_5678, 32'h8765_4321, 4'd9, 0, 0, s, w);
      check_eq("mul_stall_seq", s, k <= 3);
      check_eq("mul_wb_seq", w, k == 4);
    end
    ovr_en = 1'b0;

    // FP_ADD with setflags=0; WB in cycle 3 without flag write
    for (int k = 0; k < 5; k++) begin
      step(k == 0, FP_ADD, $urandom, $urandom, 4'd3, 0, 0, s, w);
      check_eq("add_wb_seq", w, k == 3);
    end

    // FP_DIV aborted in EXEC cycle 3, then a normal issue
    for (int k = 0; k < 5; k++) begin
      step(k == 0, FP_DIV, $urandom, $urandom, 4'd7, 1, k == 3, s, w);
      check_eq("div_abort_wb", w, 0);
      if (k == 4) begin
        check_eq("div_abort_stall", s, 0);
        check_eq("div_abort_busy", bus.busy, 0);
      end
    end
    step(1, FP_ADD, $urandom, $urandom, 4'd2, 1, 0, s, w);
    check_eq("reissue_stall", s, 1);
    idle(4);

    // start and abort together in IDLE
    step(1, FP_MUL, $urandom, $urandom, 4'd1, 1, 1, s, w);
    check_eq("start_abort_stall", s, 0);
    idle(1);
    check_eq("start_abort_busy", bus.busy, 0);

    // start held high with FP_SUB: issues at 0, 4, 8; a changes every cycle
    wb_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step(1, FP_SUB, $urandom, $urandom, 4'(k), k[0], 0, s, w);
      check_eq("sub_stall_seq", s, (k % 4) != 3);
      if (w) wb_cnt++;
    end
    check_eq("sub_wb_count", wb_cnt, 3);
    idle(4);

    // reset asserted mid-operation
    step(1, FP_DIV, $urandom, $urandom, 4'd11, 1, 0, s, w);
    idle(2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_zero_outputs("mid_rst");
    m_busy = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b1;
    idle(9);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), 2'($urandom), $urandom, $urandom,
           4'($urandom), 1'($urandom), $urandom_range(0, 15) == 0, s, w);
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
